// File: rtl/pc_sequencer.sv
// Next-PC selector with a circular return-address stack and a RUN/STALL/HALT
// control FSM; PC_In is combinational, all state changes on the rising clock edge.
module pc_sequencer #(
  parameter int          RAS_DEPTH    = 4,
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [15:0]                  PC_current,
  input  logic                         stall,
  input  logic                         branch_taken,
  input  logic [15:0]                  branch_offset,
  input  logic                         jump_en,
  input  logic [15:0]                  jump_target,
  input  logic                         call_en,
  input  logic                         ret_en,
  input  logic                         halt,
  input  logic                         resume,
  output logic [15:0]                  PC_In,
  output logic [1:0]                   state,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(RAS_DEPTH);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_HALT  = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   sp_q, sp_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic [15:0]        ras_mem_q [RAS_DEPTH];
  logic [15:0]        ras_mem_d [RAS_DEPTH];
  logic               push;
  logic [15:0]        pc_plus1;
  logic [15:0]        pc_in_c;
  logic [PTR_W-1:0]   top_idx;

  assign pc_plus1 = PC_current + 16'd1;
  assign top_idx  = sp_q - PTR_W'(1);

  always_comb begin
    pc_in_c = pc_plus1;
    state_d = state_q;
    sp_d    = sp_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    if (reset) begin
      pc_in_c = RESET_VECTOR;
    end else if (state_q == ST_HALT) begin
      pc_in_c = PC_current;
      if (resume) state_d = ST_RUN;
    end else if (halt) begin
      pc_in_c = PC_current;
      state_d = ST_HALT;
    end else if (stall) begin
      pc_in_c = PC_current;
      state_d = ST_STALL;
    end else begin
      state_d = ST_RUN;
      if (ret_en) begin
        // An empty pop falls through to the sequential PC and only raises the flag.
        if (count_q != '0) begin
          pc_in_c = ras_mem_q[top_idx];
          sp_d    = top_idx;
          count_d = count_q - CNT_W'(1);
        end else begin
          unf_d = 1'b1;
        end
      end else if (call_en) begin
        pc_in_c = jump_target;
        push    = 1'b1;
        sp_d    = sp_q + PTR_W'(1);
        if (count_q == FULL_COUNT) ovf_d = 1'b1;
        else                       count_d = count_q + CNT_W'(1);
      end else if (jump_en) begin
        pc_in_c = jump_target;
      end else if (branch_taken) begin
        pc_in_c = pc_plus1 + branch_offset;
      end
    end
  end

  // When full, sp already points at the oldest slot, so a push overwrites it.
  always_comb begin
    ras_mem_d = ras_mem_q;
    if (push) ras_mem_d[sp_q] = pc_plus1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      sp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    ras_mem_q <= ras_mem_d;
  end

  assign PC_In         = pc_in_c;
  assign state         = state_q;
  assign ras_count     = count_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack entries (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_VECTOR, default 16'h0000, meaning the PC_In value driven while reset is high.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port PC_current, input, 16 bits, the program_counter PC_output value.
REQ-006 The block SHALL have port stall, input, 1 bit, hold the PC this cycle.
REQ-007 The block SHALL have port branch_taken, input, 1 bit, conditional branch resolved taken.
REQ-008 The block SHALL have port branch_offset, input, 16 bits, two's-complement word offset.
REQ-009 The block SHALL have port jump_en, input, 1 bit, absolute jump request.
REQ-010 The block SHALL have port jump_target, input, 16 bits, absolute target for jump and call.
REQ-011 The block SHALL have port call_en, input, 1 bit, push return address and jump.
REQ-012 The block SHALL have port ret_en, input, 1 bit, pop return address.
REQ-013 The block SHALL have port halt, input, 1 bit, enter HALT.
REQ-014 The block SHALL have port resume, input, 1 bit, leave HALT.
REQ-015 The block SHALL have port PC_In, output, 16 bits, next PC to program_counter.PC_In, combinational from inputs and registered state.
REQ-016 The block SHALL have port state, output, 2 bits, registered FSM state: RUN=00, STALL=01, HALT=10.
REQ-017 The block SHALL have port ras_count, output, log2(RAS_DEPTH)+1 bits, valid stack entries.
REQ-018 The block SHALL have ports ras_overflow and ras_underflow, output, 1 bit each, sticky error flags.

Function
REQ-019 While state is HALT, PC_In SHALL equal PC_current and all requests except resume SHALL be ignored; on resume, state SHALL go to RUN next edge.
REQ-020 Otherwise, PC_In SHALL be selected by strict priority: halt, stall, ret_en, call_en, jump_en, branch_taken, sequential.
REQ-021 halt SHALL drive PC_In=PC_current, leave the stack unchanged, and set state to HALT next edge.
REQ-022 stall SHALL drive PC_In=PC_current, leave the stack unchanged, and set state to STALL next edge; with stall low, a non-HALT state SHALL become RUN next edge.
REQ-023 Sequential: PC_In SHALL be PC_current+1 mod 2^16, so 16'hFFFF -> 16'h0000.
REQ-024 branch_taken: PC_In SHALL be PC_current+1+branch_offset, sign-extended arithmetic truncated to 16 bits.
REQ-025 jump_en: PC_In SHALL be jump_target.
REQ-026 call_en: PC_In SHALL be jump_target, and PC_current+1 SHALL be pushed at the edge; if ras_count==RAS_DEPTH, the oldest entry SHALL be overwritten (circular), ras_count SHALL remain RAS_DEPTH, and ras_overflow SHALL set.
REQ-027 ret_en with ras_count>0: PC_In SHALL be the top entry, popped at the edge.
REQ-028 ret_en with ras_count==0: PC_In SHALL be PC_current+1, the stack unchanged, and ras_underflow SHALL set.
REQ-029 ret_en and call_en together SHALL perform the return only; the call is dropped with no flag.
REQ-030 Lower-priority requests coincident with a winning one SHALL have no side effect.
REQ-031 Flags SHALL clear only on reset.

Reset
REQ-032 While reset is high, PC_In SHALL equal RESET_VECTOR regardless of other inputs.
REQ-033 At a reset edge, state SHALL become RUN, ras_count 0, flags 0, stack pointer 0; reset SHALL override halt, stall or a call/ret in the same cycle.
REQ-034 Stack contents need not be cleared.

Verification
REQ-035 reset=1, PC_current=16'h1234, jump_en=1 -> PC_In=16'h0000; after the edge, state=00, ras_count=0, flags=0.
REQ-036 PC_current=16'h0010 sequential -> PC_In=16'h0011; 16'hFFFF -> 16'h0000; branch_offset=16'hFFFE at 16'h0010 -> 16'h000F.
REQ-037 call at PC_current=16'h0020, jump_target=16'h0100 -> PC_In=16'h0100 and ras_count=1; later ret -> PC_In=16'h0021 and ras_count=0.
REQ-038 Five calls from 16'h0000,1,2,3,4 with RAS_DEPTH=4 -> ras_overflow=1, ras_count=4; four rets -> 16'h0005,4,3,2; fifth ret -> PC_current+1 and ras_underflow=1.
REQ-039 stall with call_en at 16'h0040 -> PC_In=16'h0040, ras_count unchanged, state=01 next; halt then jump_en for 3 cycles -> PC_In held, state=10; resume -> state=00.
REQ-040 call_en+ret_en with one entry 16'h0055 -> PC_In=16'h0055, ras_count=0, no flags set.
